bcd_entry_decoder: RTL and testbench
====================================

// Module: bcd_entry_decoder
// PURPOSE
//  Input-side counterpart of the calculator's binary->BCD display path. Collects up to three decimal digits plus a sign.
//  Converts them to the calculator's 8-bit sign-magnitude operand {sign, mag[6:0]}.
//  Conversion is an iterative reverse double-dabble (shift right, subtract-3); the result goes to the arithmetic core over a valid/ready handshake.
// PARAMETERS
//  DIGITS  3   decimal digits accepted (BCD register = 4*DIGITS bits)
//  BIN_W   10  internal binary width = conversion iterations (ceil(log2(10^DIGITS)))
//  MAG_W   7   output magnitude width; saturation limit 2^MAG_W-1 = 127
// PORTS
//  Clk          in   1        clock, rising edge
//  Reset        in   1        reset Reset, synchronous, active-high; clock Clk
//  digit_valid  in   1        digit offered on digit
//  digit        in   4        BCD digit, MSD first
//  digit_ready  out  1        digit slot available
//  sign_toggle  in   1        one-cycle strobe, toggles entry sign
//  enter        in   1        one-cycle strobe, commit entry and start conversion
//  busy         out  1        high in CONVERT and DONE
//  out_valid    out  1        value/overflow valid
//  out_ready    in   1        consumer accepts value
//  value        out  MAG_W+1  {sign, magnitude}
//  overflow     out  1        decoded magnitude > 127, value saturated
//  digit_error  out  1        sticky: a digit > 9 was offered this entry
// BEHAVIOUR
//  Reset (any state, mid-conversion included): state=IDLE; bcd, bin, iter, count, sign, value, overflow, digit_error = 0.
//   After reset: out_valid=0, busy=0, digit_ready=1.
//  States
//   IDLE: digit_ready = (count < DIGITS).
//    On digit_valid && digit_ready: if digit<=9, bcd <= {bcd[4*DIGITS-5:0], digit} and count++.
//    Otherwise the digit is consumed but discarded, and digit_error <= 1.
//    sign_toggle: sign <= ~sign. digit_valid while count==DIGITS: ignored, no error.
//    enter: state <= CONVERT, bin <= 0, iter <= 0.
//   CONVERT: one iteration per cycle, digit_ready=0.
//    {bcd,bin} <= {bcd,bin} >> 1; then each nibble of the shifted bcd that is >=8 gets -3. iter++.
//    After iteration BIN_W: state <= DONE; magnitude and overflow are registered.
//   DONE: out_valid=1; value and overflow held stable until out_ready.
//    out_valid && out_ready: state <= IDLE, and bcd, count, sign, digit_error are cleared (the error clears with the entry).
//  Latency: enter sampled at edge t -> out_valid=1 after edge t+BIN_W (10 cycles). Throughput: one entry per handshake.
//  Width rules
//   bin > 127: overflow=1, mag=127. Otherwise overflow=0, mag=bin[6:0].
//   mag==0: sign forced to 0 (no negative zero), matching the core's zero flag.
//  Simultaneous events in IDLE, same cycle
//   digit + enter: digit is captured and included in the conversion.
//   sign_toggle + enter: toggle is applied before commit.
//   enter with count==0: converts to value=0.
//  Ignored inputs
//   enter, sign_toggle, digit_valid in CONVERT/DONE: ignored.
//   out_ready outside DONE: ignored.
// STRUCTURE
//  Shared package calc_pkg:
//   state enum {IDLE, CONVERT, DONE};
//   constants BCD_W = 4*DIGITS, MAG_MAX = 127, BCD_ADJ_THRESH = 8, BCD_ADJ = 3.
//  Sub-module bcd_digit_adj: combinational nibble corrector (d>=8 ? d-3 : d).
//   Instantiated DIGITS times in a generate loop.
//  Top holds the FSM, iteration counter (clog2(BIN_W+1) bits), digit counter, and BCD/binary shift registers.
// TESTING
//  Digits 1,2,7, enter -> out_valid after 10 cycles, value=8'h7F, overflow=0; out_ready -> IDLE, digit_ready=1.
//  Digits 2,5,5, sign_toggle, enter -> value=8'hFF (sign 1, mag 127), overflow=1.
//  Digit 4, sign_toggle, enter with out_ready=0 for 5 cycles -> value=8'h84 held stable; accepted on out_ready.
//  Digits 0,0,0, sign_toggle, enter -> value=8'h00 (sign suppressed), overflow=0.
//  Digit 4'hB then 3, enter -> digit_error=1, value=8'h03; error clears after handshake.
//  Digits 9,9 then Reset in CONVERT iteration 5 -> IDLE next cycle, out_valid=0; a following entry of 5 decodes to 8'h05.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator types and constants.
// Used by the BCD entry path and its nibble corrector.
package calc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam int DIGITS         = 3;
   localparam int BIN_W          = 10;
   localparam int MAG_W          = 7;
   localparam int BCD_W          = 4 * DIGITS;
   localparam int MAG_MAX        = (2 ** MAG_W) - 1;
   localparam int BCD_ADJ_THRESH = 8;
   localparam int BCD_ADJ        = 3;
   localparam int ITER_W         = $clog2(BIN_W + 1);
   localparam int CNT_W          = $clog2(DIGITS + 1);

endpackage

// File: rtl/bcd_digit_adj.sv
// Nibble corrector for reverse double-dabble.
// A shifted-in half-ten (>=8) is pulled back by 3.
module bcd_digit_adj
   import calc_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [3:0] nib_o
);

   // Subtract 3 from any nibble that landed at 8 or above
   always_comb begin
      nib_o = nib_i;
      if (nib_i >= 4'(BCD_ADJ_THRESH)) begin
         nib_o = nib_i - 4'(BCD_ADJ);
      end
   end

endmodule

// File: rtl/bcd_entry_decoder.sv
// Decimal keypad entry to 8-bit sign-magnitude operand.
// Iterative reverse double-dabble, valid/ready result.
module bcd_entry_decoder
   import calc_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             digit_valid,
   input  logic [3:0]       digit,
   output logic             digit_ready,
   input  logic             sign_toggle,
   input  logic             enter,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [MAG_W:0]   value,
   output logic             overflow,
   output logic             digit_error
);

   state_t             state_q, state_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic [ITER_W-1:0]  iter_q, iter_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               sign_q, sign_d;
   logic [MAG_W:0]     value_q, value_d;
   logic               ovf_q, ovf_d;
   logic               err_q, err_d;

   logic [BCD_W-1:0]   bcd_shr;
   logic [BCD_W-1:0]   bcd_adj;
   logic [BIN_W-1:0]   bin_shr;
   logic               ovf_c;
   logic [MAG_W-1:0]   mag_c;
   logic               sign_c;
   logic               dig_take;
   logic               dig_ok;
   logic               last_iter;

   assign {bcd_shr, bin_shr} = {bcd_q, bin_q} >> 1;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_adj
         bcd_digit_adj u_adj (
            .nib_i (bcd_shr[4*g +: 4]),
            .nib_o (bcd_adj[4*g +: 4])
         );
      end
   endgenerate

   assign ovf_c  = (bin_shr > BIN_W'(MAG_MAX));
   assign mag_c  = ovf_c ? MAG_W'(MAG_MAX) : bin_shr[MAG_W-1:0];
   assign sign_c = sign_q & (mag_c != '0);

   assign digit_ready = (state_q == IDLE)
                      && (count_q < CNT_W'(DIGITS));
   assign dig_take    = digit_valid & digit_ready;
   assign dig_ok      = (digit <= 4'd9);
   assign last_iter   = (iter_q == ITER_W'(BIN_W - 1));

   assign busy        = (state_q == CONVERT) || (state_q == DONE);
   assign out_valid   = (state_q == DONE);
   assign value       = value_q;
   assign overflow    = ovf_q;
   assign digit_error = err_q;

   // Next-state: entry capture, conversion steps, result hand-off
   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      bin_d   = bin_q;
      iter_d  = iter_q;
      count_d = count_q;
      sign_d  = sign_q;
      value_d = value_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (dig_take) begin
               if (dig_ok) begin
                  bcd_d   = {bcd_q[BCD_W-5:0], digit};
                  count_d = count_q + 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            if (sign_toggle) begin
               sign_d = ~sign_q;
            end
            if (enter) begin
               state_d = CONVERT;
               bin_d   = '0;
               iter_d  = '0;
            end
         end
         CONVERT: begin
            bcd_d  = bcd_adj;
            bin_d  = bin_shr;
            iter_d = iter_q + 1'b1;
            if (last_iter) begin
               state_d = DONE;
               value_d = {sign_c, mag_c};
               ovf_d   = ovf_c;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
               bcd_d   = '0;
               count_d = '0;
               sign_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers, synchronous reset
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         bcd_q   <= '0;
         bin_q   <= '0;
         iter_q  <= '0;
         count_q <= '0;
         sign_q  <= 1'b0;
         value_q <= '0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         bin_q   <= bin_d;
         iter_q  <= iter_d;
         count_q <= count_d;
         sign_q  <= sign_d;
         value_q <= value_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_bcd_entry_decoder.sv
// Directed bench for the BCD entry decoder.
// Each scenario task checks its own expectations inline.
module tb_bcd_entry_decoder;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       digit_valid = 1'b0;
   logic [3:0] digit = '0;
   logic       digit_ready;
   logic       sign_toggle = 1'b0;
   logic       enter = 1'b0;
   logic       busy;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] value;
   logic       overflow;
   logic       digit_error;

   int tests = 0;
   int fails = 0;

   bcd_entry_decoder dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .digit_valid (digit_valid),
      .digit       (digit),
      .digit_ready (digit_ready),
      .sign_toggle (sign_toggle),
      .enter       (enter),
      .busy        (busy),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .value       (value),
      .overflow    (overflow),
      .digit_error (digit_error)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic put_digit(input logic [3:0] d);
      digit_valid = 1'b1;
      digit       = d;
      step();
      digit_valid = 1'b0;
   endtask

   task automatic put_sign();
      sign_toggle = 1'b1;
      step();
      sign_toggle = 1'b0;
   endtask

   task automatic put_enter();
      enter = 1'b1;
      step();
      enter = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      step();
      step();
      Reset = 1'b0;
      tests++;
      if ({out_valid, busy, digit_ready} !== 3'b001) begin
         fails++;
         $display("FAIL reset_ctl got %b want 001",
                  {out_valid, busy, digit_ready});
      end
      tests++;
      if ({value, overflow, digit_error} !== 10'h0) begin
         fails++;
         $display("FAIL reset_data got %h/%b/%b want 00/0/0",
                  value, overflow, digit_error);
      end
   endtask

   task automatic test_basic();
      int n;
      put_digit(4'd1);
      put_digit(4'd2);
      put_digit(4'd7);
      tests++;
      if (digit_ready !== 1'b0) begin
         fails++;
         $display("FAIL full_ready got %b want 0", digit_ready);
      end
      put_digit(4'd8);
      tests++;
      if (digit_error !== 1'b0) begin
         fails++;
         $display("FAIL full_noerr got %b want 0", digit_error);
      end
      put_enter();
      tests++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL conv_busy got %b%b want 10",
                  busy, out_valid);
      end
      wait_valid(n);
      tests++;
      if (n !== 10) begin
         fails++;
         $display("FAIL latency got %0d want 10", n);
      end
      tests++;
      if (value !== 8'h7F || overflow !== 1'b0) begin
         fails++;
         $display("FAIL val127 got %h/%b want 7f/0",
                  value, overflow);
      end
      handshake();
      tests++;
      if ({out_valid, busy, digit_ready} !== 3'b001) begin
         fails++;
         $display("FAIL post_hs got %b want 001",
                  {out_valid, busy, digit_ready});
      end
   endtask

   task automatic test_overflow();
      int n;
      put_digit(4'd2);
      put_digit(4'd5);
      put_digit(4'd5);
      put_sign();
      put_enter();
      wait_valid(n);
      tests++;
      if (value !== 8'hFF || overflow !== 1'b1 || n !== 10) begin
         fails++;
         $display("FAIL ovf255 got %h/%b n=%0d want ff/1 n=10",
                  value, overflow, n);
      end
      handshake();
   endtask

   task automatic test_hold();
      int  n;
      bit  stable;
      put_digit(4'd4);
      put_sign();
      put_enter();
      wait_valid(n);
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         enter       = 1'b1;
         sign_toggle = 1'b1;
         digit_valid = 1'b1;
         digit       = 4'd9;
         step();
         if (value !== 8'h84 || out_valid !== 1'b1) begin
            stable = 1'b0;
         end
      end
      enter       = 1'b0;
      sign_toggle = 1'b0;
      digit_valid = 1'b0;
      tests++;
      if (stable !== 1'b1 || value !== 8'h84) begin
         fails++;
         $display("FAIL hold got %h stable=%b want 84 stable=1",
                  value, stable);
      end
      handshake();
      tests++;
      if (out_valid !== 1'b0 || digit_ready !== 1'b1) begin
         fails++;
         $display("FAIL hold_hs got %b%b want 01",
                  out_valid, digit_ready);
      end
   endtask

   task automatic test_zero();
      int n;
      put_digit(4'd0);
      put_digit(4'd0);
      put_digit(4'd0);
      put_sign();
      put_enter();
      wait_valid(n);
      tests++;
      if (value !== 8'h00 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL negzero got %h/%b want 00/0",
                  value, overflow);
      end
      handshake();
      put_enter();
      wait_valid(n);
      tests++;
      if (value !== 8'h00 || n !== 10) begin
         fails++;
         $display("FAIL empty got %h n=%0d want 00 n=10",
                  value, n);
      end
      handshake();
   endtask

   task automatic test_digit_error();
      int n;
      put_digit(4'hB);
      tests++;
      if (digit_error !== 1'b1 || digit_ready !== 1'b1) begin
         fails++;
         $display("FAIL bad_digit got %b%b want 11",
                  digit_error, digit_ready);
      end
      put_digit(4'd3);
      put_enter();
      wait_valid(n);
      tests++;
      if (value !== 8'h03 || digit_error !== 1'b1) begin
         fails++;
         $display("FAIL err_val got %h/%b want 03/1",
                  value, digit_error);
      end
      handshake();
      tests++;
      if (digit_error !== 1'b0) begin
         fails++;
         $display("FAIL err_clear got %b want 0", digit_error);
      end
   endtask

   task automatic test_same_cycle();
      int n;
      put_digit(4'd4);
      digit_valid = 1'b1;
      digit       = 4'd6;
      sign_toggle = 1'b1;
      enter       = 1'b1;
      step();
      digit_valid = 1'b0;
      sign_toggle = 1'b0;
      enter       = 1'b0;
      wait_valid(n);
      tests++;
      if (value !== 8'hAE || overflow !== 1'b0 || n !== 10) begin
         fails++;
         $display("FAIL same_cyc got %h/%b n=%0d want ae/0 n=10",
                  value, overflow, n);
      end
      handshake();
   endtask

   task automatic test_reset_mid();
      int n;
      put_digit(4'd9);
      put_digit(4'd9);
      put_enter();
      for (int i = 0; i < 4; i++) begin
         step();
      end
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      tests++;
      if ({out_valid, busy, digit_ready} !== 3'b001) begin
         fails++;
         $display("FAIL mid_rst got %b want 001",
                  {out_valid, busy, digit_ready});
      end
      put_digit(4'd5);
      put_enter();
      wait_valid(n);
      tests++;
      if (value !== 8'h05 || overflow !== 1'b0 || n !== 10) begin
         fails++;
         $display("FAIL after_rst got %h/%b n=%0d want 05/0 n=10",
                  value, overflow, n);
      end
      handshake();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_hold();
      test_zero();
      test_digit_error();
      test_same_cycle();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
